// File: rtl/camera_downsampler_pkg.sv
// Shared definitions for the camera capture path: frame geometry, RGB332
// colour constants and the capture FSM state encoding.
package camera_downsampler_pkg;

    localparam int SCREEN_WIDTH  = 176;
    localparam int SCREEN_HEIGHT = 144;
    localparam int ADDR_W        = 15;

    // RGB332 colours, also used by test-pattern writers sharing this buffer
    localparam logic [7:0] RED   = 8'hE0;
    localparam logic [7:0] GREEN = 8'h1C;
    localparam logic [7:0] BLUE  = 8'h03;
    localparam logic [7:0] WHITE = 8'hFF;

    typedef enum logic [1:0] {
        WAIT_VS_HI = 2'd0,
        WAIT_VS_LO = 2'd1,
        IN_FRAME   = 2'd2
    } state_t;

endpackage

// File: rtl/camera_downsampler_if.sv
// Camera-side bus plus frame-buffer write port of the downsampler.
// master: the camera/frame-buffer environment; slave: the downsampler.
interface camera_downsampler_if #(
    parameter int ADDR_W = camera_downsampler_pkg::ADDR_W
);
    logic              VSYNC;
    logic              HREF;
    logic [7:0]        DATA;
    logic [7:0]        PIXEL_OUT;
    logic [ADDR_W-1:0] W_ADDR;
    logic              W_EN;
    logic              FRAME_DONE;
    logic              SYNC_ERR;

    modport master (
        output VSYNC, HREF, DATA,
        input  PIXEL_OUT, W_ADDR, W_EN, FRAME_DONE, SYNC_ERR
    );

    modport slave (
        input  VSYNC, HREF, DATA,
        output PIXEL_OUT, W_ADDR, W_EN, FRAME_DONE, SYNC_ERR
    );
endinterface

// File: rtl/camera_downsampler_rgb565_to_rgb332.sv
// Combinational RGB565 -> RGB332 packer: keeps the top 3/3/2 bits of R/G/B.
module camera_downsampler_rgb565_to_rgb332 (
    input  logic [15:0] rgb565,
    output logic [7:0]  rgb332
);
    // Low colour bits are truncated away on purpose
    logic unused_low_bits;

    assign rgb332          = {rgb565[15:13], rgb565[10:8], rgb565[4:3]};
    assign unused_low_bits = ^{rgb565[12:11], rgb565[7:5], rgb565[2:0]};
endmodule

// File: rtl/camera_downsampler.sv
// Captures the OV7670 RGB565 byte stream, packs pixels to RGB332 and writes
// them into the frame buffer at y*SCREEN_WIDTH + x. Only whole frames
// (after a complete VSYNC high/low pulse) are captured.
module camera_downsampler #(
    parameter int SCREEN_WIDTH  = camera_downsampler_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = camera_downsampler_pkg::SCREEN_HEIGHT,
    parameter int ADDR_W        = camera_downsampler_pkg::ADDR_W
) (
    input  logic                CLOCK,
    input  logic                RESET,
    camera_downsampler_if.slave bus
);
    import camera_downsampler_pkg::*;

    localparam int XW = $clog2(SCREEN_WIDTH + 1);
    localparam int YW = $clog2(SCREEN_HEIGHT + 1);
    localparam logic [XW-1:0]     X_MAX     = XW'(SCREEN_WIDTH);
    localparam logic [YW-1:0]     Y_MAX     = YW'(SCREEN_HEIGHT);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(SCREEN_WIDTH);

    state_t            state, state_n;
    logic              vs_q, href_q;
    logic              vs_rise, href_fall;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [ADDR_W-1:0] line_base, line_base_n;
    logic              phase, phase_n;
    logic [7:0]        hi_byte, hi_byte_n;
    logic [7:0]        packed_px;
    logic [7:0]        pixel_out, pixel_out_n;
    logic [ADDR_W-1:0] w_addr, w_addr_n;
    logic              w_en, w_en_n;
    logic              frame_done, frame_done_n;
    logic              sync_err, sync_err_n;

    assign vs_rise   = bus.VSYNC & ~vs_q;
    assign href_fall = href_q & ~bus.HREF;

    // The second byte comes straight off the bus so the pixel is ready on that edge
    camera_downsampler_rgb565_to_rgb332 u_pack (
        .rgb565 ({hi_byte, bus.DATA}),
        .rgb332 (packed_px)
    );

    // FSM state register
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= WAIT_VS_HI;
        else       state <= state_n;
    end

    // Next state, capture bookkeeping and write strobes
    always_comb begin
        state_n      = state;
        x_n          = x;
        y_n          = y;
        line_base_n  = line_base;
        phase_n      = phase;
        hi_byte_n    = hi_byte;
        pixel_out_n  = pixel_out;
        w_addr_n     = w_addr;
        w_en_n       = 1'b0;
        frame_done_n = 1'b0;
        sync_err_n   = sync_err;
        unique case (state)
            WAIT_VS_HI: begin
                if (bus.VSYNC) state_n = WAIT_VS_LO;
            end
            WAIT_VS_LO: begin
                if (!bus.VSYNC) begin
                    state_n     = IN_FRAME;
                    x_n         = '0;
                    y_n         = '0;
                    line_base_n = '0;
                    phase_n     = 1'b0;
                    sync_err_n  = 1'b0;
                end
            end
            IN_FRAME: begin
                // Frame end has priority over a coincident line end
                if (vs_rise) begin
                    state_n      = WAIT_VS_LO;
                    frame_done_n = 1'b1;
                end else if (bus.HREF) begin
                    if (!phase) begin
                        hi_byte_n = bus.DATA;
                        phase_n   = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (x < X_MAX && y < Y_MAX) begin
                            w_en_n      = 1'b1;
                            w_addr_n    = line_base + ADDR_W'(x);
                            pixel_out_n = packed_px;
                        end else begin
                            sync_err_n = 1'b1;
                        end
                        if (x < X_MAX) x_n = x + XW'(1);
                    end
                end else if (href_fall) begin
                    // A dangling high byte means the line lost a byte
                    if (phase) sync_err_n = 1'b1;
                    phase_n = 1'b0;
                    if (x != '0) begin
                        x_n = '0;
                        if (y < Y_MAX) begin
                            y_n         = y + YW'(1);
                            line_base_n = line_base + LINE_STEP;
                        end
                    end
                end
            end
            default: state_n = WAIT_VS_HI;
        endcase
    end

    // Sync edge-detect registers, counters and frame-buffer outputs
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            vs_q       <= 1'b0;
            href_q     <= 1'b0;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            phase      <= 1'b0;
            pixel_out  <= '0;
            w_addr     <= '0;
            w_en       <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            vs_q       <= bus.VSYNC;
            href_q     <= bus.HREF;
            x          <= x_n;
            y          <= y_n;
            line_base  <= line_base_n;
            phase      <= phase_n;
            pixel_out  <= pixel_out_n;
            w_addr     <= w_addr_n;
            w_en       <= w_en_n;
            frame_done <= frame_done_n;
            sync_err   <= sync_err_n;
        end
    end

    // High byte holding register; only read once phase says it is valid
    always_ff @(posedge CLOCK) begin
        hi_byte <= hi_byte_n;
    end

    assign bus.PIXEL_OUT  = pixel_out;
    assign bus.W_ADDR     = w_addr;
    assign bus.W_EN       = w_en;
    assign bus.FRAME_DONE = frame_done;
    assign bus.SYNC_ERR   = sync_err;
endmodule

// File: tb/tb_camera_downsampler.sv
// Testbench for camera_downsampler: randomized camera streams against a
// frame-level reference model of where each pixel must land.
module tb_camera_downsampler;
    import camera_downsampler_pkg::*;

    localparam int W = SCREEN_WIDTH;
    localparam int H = SCREEN_HEIGHT;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        pix;
        int unsigned       cyc;
    } wr_t;

    logic CLOCK = 1'b0;
    logic RESET;

    camera_downsampler_if bus ();

    camera_downsampler dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    int          fd_cnt = 0;
    wr_t         got_q[$];
    wr_t         exp_q[$];
    logic [7:0]  line_bytes[$];

    // Reference model state: whether the DUT is capturing, line index, error, frame-done count
    bit m_active = 1'b0;
    int m_y      = 0;
    bit m_err    = 1'b0;
    int m_fd     = 0;

    always @(posedge CLOCK) cyc <= cyc + 1;

    always @(negedge CLOCK) begin
        wr_t r;
        if (bus.W_EN === 1'b1) begin
            r.addr = bus.W_ADDR;
            r.pix  = bus.PIXEL_OUT;
            r.cyc  = cyc;
            got_q.push_back(r);
        end
        if (bus.FRAME_DONE === 1'b1) fd_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] ref_pix(input int hi, input int lo);
        int v, r5, g6, b5;
        v  = hi * 256 + lo;
        r5 = v / 2048;
        g6 = (v / 32) % 64;
        b5 = v % 32;
        return 8'((r5 / 4) * 32 + (g6 / 8) * 4 + b5 / 8);
    endfunction

    task automatic fill_random(input int n);
        line_bytes.delete();
        repeat (n) line_bytes.push_back(8'($urandom));
    endtask

    task automatic drive_bytes(input int first, input int count);
        for (int i = first; i < first + count; i++) begin
            wr_t e;
            int  px;
            @(negedge CLOCK);
            bus.HREF = 1'b1;
            bus.DATA = line_bytes[i];
            if (m_active && (i % 2) == 1) begin
                px = i / 2;
                if (px < W && m_y < H) begin
                    e.addr = ADDR_W'(m_y * W + px);
                    e.pix  = ref_pix(int'(line_bytes[i-1]), int'(line_bytes[i]));
                    e.cyc  = cyc + 1;
                    exp_q.push_back(e);
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    endtask

    task automatic end_line(input int gap);
        @(negedge CLOCK);
        bus.HREF = 1'b0;
        bus.DATA = 8'($urandom);
        if (m_active) begin
            if ((line_bytes.size() % 2) == 1) m_err = 1'b1;
            if (line_bytes.size() >= 2 && m_y < H) m_y++;
        end
        repeat (gap) @(negedge CLOCK);
    endtask

    task automatic drive_line(input int gap);
        drive_bytes(0, line_bytes.size());
        end_line(gap);
    endtask

    task automatic vsync_pulse();
        @(negedge CLOCK);
        bus.HREF  = 1'b0;
        bus.VSYNC = 1'b1;
        if (m_active) m_fd++;
        repeat (2) @(negedge CLOCK);
        bus.VSYNC = 1'b0;
        repeat (3) @(negedge CLOCK);
        m_active = 1'b1;
        m_y      = 0;
        m_err    = 1'b0;
    endtask

    task automatic test_reset();
        RESET     = 1'b1;
        bus.VSYNC = 1'b0;
        bus.HREF  = 1'b1;
        bus.DATA  = 8'($urandom);
        repeat (3) @(negedge CLOCK);
        checks++; if (bus.W_EN !== 1'b0) begin errors++; $display("FAIL reset_w_en got %b exp 0", bus.W_EN); end
        checks++; if (bus.W_ADDR !== '0) begin errors++; $display("FAIL reset_w_addr got %0d exp 0", bus.W_ADDR); end
        checks++; if (bus.PIXEL_OUT !== 8'h00) begin errors++; $display("FAIL reset_pixel got %h exp 00", bus.PIXEL_OUT); end
        checks++; if (bus.FRAME_DONE !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b exp 0", bus.FRAME_DONE); end
        checks++; if (bus.SYNC_ERR !== 1'b0) begin errors++; $display("FAIL reset_sync_err got %b exp 0", bus.SYNC_ERR); end
        bus.HREF = 1'b0;
        RESET    = 1'b0;
        m_active = 1'b0;
        m_err    = 1'b0;
        @(negedge CLOCK);
        got_q.delete();
        exp_q.delete();
        fd_cnt = 0;
        m_fd   = 0;
    endtask

    task automatic test_full_frame();
        vsync_pulse();
        line_bytes.delete();
        for (int i = 0; i < 176; i++) begin
            line_bytes.push_back(8'hF8);
            line_bytes.push_back(8'h00);
        end
        for (int l = 0; l < 144; l++) drive_line(2);
        checks++; if (got_q.size() !== 25344) begin errors++; $display("FAIL t1_count got %0d exp 25344", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0].pix !== RED) begin errors++; $display("FAIL t1_first_pix got %h exp %h", got_q[0].pix, RED); end
            checks++; if (got_q[got_q.size()-1].addr !== 15'd25343) begin errors++; $display("FAIL t1_last_addr got %0d exp 25343", got_q[got_q.size()-1].addr); end
        end
        checks++; if (bus.SYNC_ERR !== 1'b0) begin errors++; $display("FAIL t1_sync_err got %b exp 0", bus.SYNC_ERR); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL t1_model_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t1_write[%0d] got a=%0d p=%h c=%0d exp a=%0d p=%h c=%0d", i, got_q[i].addr, got_q[i].pix, got_q[i].cyc, exp_q[i].addr, exp_q[i].pix, exp_q[i].cyc);
            end
        end
        got_q.delete(); exp_q.delete();
        vsync_pulse();
        checks++; if (fd_cnt !== 1) begin errors++; $display("FAIL t1_frame_done got %0d exp 1", fd_cnt); end
    endtask

    task automatic test_pixel_values();
        logic [7:0] exp_pix [4] = '{GREEN, BLUE, WHITE, 8'h00};
        line_bytes = '{8'h07, 8'hE0, 8'h00, 8'h1F, 8'hFF, 8'hFF, 8'h00, 8'h00};
        repeat (16) line_bytes.push_back(8'($urandom));
        drive_line(3);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (got_q.size() <= k || got_q[k].pix !== exp_pix[k] || got_q[k].addr !== ADDR_W'(k)) begin
                errors++;
                $display("FAIL t2_pattern[%0d] got a=%0d p=%h exp a=%0d p=%h", k, (got_q.size() > k) ? int'(got_q[k].addr) : -1, (got_q.size() > k) ? got_q[k].pix : 8'hxx, k, exp_pix[k]);
            end
        end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL t2_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t2_write[%0d] got a=%0d p=%h c=%0d exp a=%0d p=%h c=%0d", i, got_q[i].addr, got_q[i].pix, got_q[i].cyc, exp_q[i].addr, exp_q[i].pix, exp_q[i].cyc);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 2; f++) begin
            vsync_pulse();
            for (int l = 0; l < int'($urandom_range(6, 12)); l++) begin
                fill_random(int'($urandom_range(0, 400)));
                drive_line(int'($urandom_range(1, 4)));
            end
            checks++;
            if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd_count frame %0d got %0d exp %0d", f, got_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rnd_write[%0d] got a=%0d p=%h c=%0d exp a=%0d p=%h c=%0d", i, got_q[i].addr, got_q[i].pix, got_q[i].cyc, exp_q[i].addr, exp_q[i].pix, exp_q[i].cyc);
                end
            end
            got_q.delete(); exp_q.delete();
            checks++; if (bus.SYNC_ERR !== m_err) begin errors++; $display("FAIL rnd_sync_err frame %0d got %b exp %b", f, bus.SYNC_ERR, m_err); end
        end
        vsync_pulse();
        checks++; if (fd_cnt !== m_fd) begin errors++; $display("FAIL rnd_frame_done got %0d exp %0d", fd_cnt, m_fd); end
    endtask

    task automatic test_mid_frame_reset();
        @(negedge CLOCK);
        RESET     = 1'b1;
        bus.VSYNC = 1'b0;
        repeat (2) @(negedge CLOCK);
        RESET    = 1'b0;
        m_active = 1'b0;
        m_err    = 1'b0;
        for (int l = 0; l < 3; l++) begin
            fill_random(40);
            drive_line(2);
        end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL t3_no_write got %0d writes exp 0", got_q.size()); end
        got_q.delete(); exp_q.delete();
        vsync_pulse();
        fill_random(20);
        drive_line(2);
        checks++; if (got_q.size() == 0 || got_q[0].addr !== '0) begin errors++; $display("FAIL t3_first_addr got %0d exp 0 (writes %0d)", (got_q.size() > 0) ? int'(got_q[0].addr) : -1, got_q.size()); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL t3_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t3_write[%0d] got a=%0d p=%h exp a=%0d p=%h", i, got_q[i].addr, got_q[i].pix, exp_q[i].addr, exp_q[i].pix);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_long_line();
        vsync_pulse();
        fill_random(360);
        drive_line(2);
        fill_random(20);
        drive_line(2);
        checks++; if (got_q.size() !== 186) begin errors++; $display("FAIL t4_count got %0d exp 186", got_q.size()); end
        checks++; if (got_q.size() < 177 || got_q[176].addr !== 15'd176) begin errors++; $display("FAIL t4_next_line_addr got %0d exp 176", (got_q.size() > 176) ? int'(got_q[176].addr) : -1); end
        checks++; if (bus.SYNC_ERR !== 1'b1) begin errors++; $display("FAIL t4_sync_err got %b exp 1", bus.SYNC_ERR); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL t4_model_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t4_write[%0d] got a=%0d p=%h exp a=%0d p=%h", i, got_q[i].addr, got_q[i].pix, exp_q[i].addr, exp_q[i].pix);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_odd_line();
        vsync_pulse();
        fill_random(351);
        drive_line(2);
        checks++; if (got_q.size() !== 175) begin errors++; $display("FAIL t5_count got %0d exp 175", got_q.size()); end
        checks++; if (bus.SYNC_ERR !== 1'b1) begin errors++; $display("FAIL t5_sync_err got %b exp 1", bus.SYNC_ERR); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL t5_model_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t5_write[%0d] got a=%0d p=%h exp a=%0d p=%h", i, got_q[i].addr, got_q[i].pix, exp_q[i].addr, exp_q[i].pix);
            end
        end
        got_q.delete(); exp_q.delete();
        vsync_pulse();
        checks++; if (bus.SYNC_ERR !== 1'b0) begin errors++; $display("FAIL t5_sync_err_cleared got %b exp 0", bus.SYNC_ERR); end
    endtask

    task automatic test_reset_mid_line();
        fill_random(200);
        drive_bytes(0, 100);
        @(negedge CLOCK);
        RESET    = 1'b1;
        bus.DATA = 8'($urandom);
        m_active = 1'b0;
        m_err    = 1'b0;
        @(posedge CLOCK);
        #1;
        checks++; if (bus.W_EN !== 1'b0) begin errors++; $display("FAIL t6_rst_w_en got %b exp 0", bus.W_EN); end
        checks++; if (bus.W_ADDR !== '0) begin errors++; $display("FAIL t6_rst_w_addr got %0d exp 0", bus.W_ADDR); end
        checks++; if (bus.PIXEL_OUT !== 8'h00) begin errors++; $display("FAIL t6_rst_pixel got %h exp 00", bus.PIXEL_OUT); end
        @(negedge CLOCK);
        RESET = 1'b0;
        drive_bytes(100, 100);
        end_line(2);
        fill_random(40);
        drive_line(2);
        checks++; if (got_q.size() !== 50) begin errors++; $display("FAIL t6_pre_reset_writes got %0d exp 50", got_q.size()); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL t6_model_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t6_write[%0d] got a=%0d p=%h exp a=%0d p=%h", i, got_q[i].addr, got_q[i].pix, exp_q[i].addr, exp_q[i].pix);
            end
        end
        got_q.delete(); exp_q.delete();
        vsync_pulse();
        for (int l = 0; l < 150; l++) begin
            fill_random(4);
            drive_line(2);
        end
        checks++; if (got_q.size() !== 288) begin errors++; $display("FAIL t6_tall_count got %0d exp 288", got_q.size()); end
        checks++; if (got_q.size() == 0 || got_q[got_q.size()-1].addr !== 15'd25169) begin errors++; $display("FAIL t6_tall_last_addr got %0d exp 25169", (got_q.size() > 0) ? int'(got_q[got_q.size()-1].addr) : -1); end
        checks++; if (bus.SYNC_ERR !== 1'b1) begin errors++; $display("FAIL t6_tall_sync_err got %b exp 1", bus.SYNC_ERR); end
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL t6_tall_model_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL t6_tall_write[%0d] got a=%0d p=%h exp a=%0d p=%h", i, got_q[i].addr, got_q[i].pix, exp_q[i].addr, exp_q[i].pix);
            end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        bus.VSYNC = 1'b0;
        bus.HREF  = 1'b0;
        bus.DATA  = 8'h00;
        RESET     = 1'b1;
        test_reset();
        test_full_frame();
        test_pixel_values();
        test_random_frames();
        test_mid_frame_reset();
        test_long_line();
        test_odd_line();
        test_reset_mid_line();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
